// File: rtl/sram_pkg.sv
// sram_pkg: shared FSM states, SRAM command field positions and the command builder.
package sram_pkg;
    typedef enum logic [2:0] {IDLE, LO, GAP, HI, DONE} state_t;
    localparam int MOSI_W        = 36;
    localparam int MOSI_RW_BIT   = 35;
    localparam int MOSI_DATA_MSB = 34;
    localparam int MOSI_DATA_LSB = 19;
    localparam int SRAM_ADDR_W   = 19;
    localparam int SRAM_DATA_W   = 16;

    function automatic logic [MOSI_W-1:0] mk_mosi(
        input logic                   rw,
        input logic [SRAM_DATA_W-1:0] data,
        input logic [SRAM_ADDR_W-1:0] haddr
    );
        logic [MOSI_W-1:0] m;
        m = '0;
        m[MOSI_RW_BIT] = rw;
        m[MOSI_DATA_MSB:MOSI_DATA_LSB] = data;
        m[SRAM_ADDR_W-1:0] = haddr;
        return m;
    endfunction
endpackage

// File: rtl/sram_ctrl.sv
// sram_ctrl: splits a 32-bit CPU access into two 16-bit SRAM phases (low, then high half-word)
// separated by a one-cycle deselect gap; all SRAM-side and CPU-side outputs are registered.
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic                   sck,
    input  logic                   rst,
    input  logic                   req,
    input  logic                   we,
    input  logic [31:0]            addr,
    input  logic [31:0]            wdata,
    output logic [31:0]            rdata,
    output logic                   ack,
    output logic                   busy,
    output logic                   cs_n,
    output logic [MOSI_W-1:0]      mosi,
    input  logic [SRAM_DATA_W-1:0] miso
);
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t            r_state, w_next;
    logic [3:0]        r_cnt, w_cnt;
    logic              r_we, w_we;
    logic [17:0]       r_haddr, w_haddr;
    logic [31:0]       r_wdata, w_wdata, r_rdata;
    logic              r_ack, r_busy, r_cs_n;
    logic [MOSI_W-1:0] r_mosi, w_mosi;
    logic              w_phase, w_last, w_unused_addr;

    assign w_unused_addr = ^{addr[31:20], addr[1:0]};
    assign w_last = (r_cnt == 4'd0);

    always_ff @(posedge sck) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_haddr <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt;
            r_we    <= w_we;
            r_haddr <= w_haddr;
            r_wdata <= w_wdata;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = req ? LO : IDLE;
            LO:      w_next = w_last ? GAP : LO;
            GAP:     w_next = HI;
            HI:      w_next = w_last ? DONE : HI;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Request fields pass straight through only in IDLE, so they are frozen for the whole access.
    always_comb begin
        w_we    = (r_state == IDLE) ? we : r_we;
        w_haddr = (r_state == IDLE) ? addr[19:2] : r_haddr;
        w_wdata = (r_state == IDLE) ? wdata : r_wdata;
        w_phase = (w_next == LO) || (w_next == HI);
        w_cnt   = (w_phase && w_next != r_state) ? CNT_LOAD : (w_last ? 4'd0 : r_cnt - 4'd1);
        w_mosi  = (w_next == LO) ? mk_mosi(w_we, w_we ? w_wdata[15:0] : 16'h0, {w_haddr, 1'b0}) :
                  (w_next == HI) ? mk_mosi(w_we, w_we ? w_wdata[31:16] : 16'h0, {w_haddr, 1'b1}) :
                  '0;
    end

    always_ff @(posedge sck) begin
        if (rst) begin
            r_rdata <= '0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
            r_cs_n  <= 1'b1;
            r_mosi  <= '0;
        end else begin
            r_ack  <= (w_next == DONE);
            r_busy <= (w_next != IDLE);
            r_cs_n <= !w_phase;
            r_mosi <= w_mosi;
            if (!r_we && w_last && r_state == LO) r_rdata[15:0] <= miso;
            if (!r_we && w_last && r_state == HI) r_rdata[31:16] <= miso;
        end
    end

    assign rdata = r_rdata;
    assign ack   = r_ack;
    assign busy  = r_busy;
    assign cs_n  = r_cs_n;
    assign mosi  = r_mosi;
endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: directed vectors for sram_ctrl at WAIT_CYCLES=1 and 3 against a small SRAM model.
module tb_sram_ctrl;
    logic        sck = 1'b0, rst = 1'b1, req = 1'b0, req3 = 1'b0, we = 1'b0;
    logic [31:0] addr = '0, wdata = '0, rdata1, rdata3;
    logic        ack1, busy1, cs_n1, ack3, busy3, cs_n3;
    logic [35:0] mosi1, mosi3;
    logic [15:0] miso1, miso3;
    logic [15:0] mem [0:1023];
    int          low3 = 0;
    int          checks = 0, failures = 0;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [35:0] lo;
        logic [35:0] hi;
        logic [31:0] rd;
    } vec_t;
    vec_t vecs [8];

    always #5 sck = ~sck;

    sram_ctrl #(.WAIT_CYCLES(1)) u_dut1 (
        .sck(sck), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata1), .ack(ack1), .busy(busy1), .cs_n(cs_n1), .mosi(mosi1), .miso(miso1)
    );
    sram_ctrl #(.WAIT_CYCLES(3)) u_dut3 (
        .sck(sck), .rst(rst), .req(req3), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata3), .ack(ack3), .busy(busy3), .cs_n(cs_n3), .mosi(mosi3), .miso(miso3)
    );

    // The slow SRAM only presents valid data once the address has been held for three cycles.
    assign miso1 = cs_n1 ? 16'hBAD0 : mem[mosi1[9:0]];
    assign miso3 = cs_n3 ? 16'hBAD0 : (low3 == 2 ? mem[mosi3[9:0]] : 16'hBAD1);

    always @(posedge sck) begin
        if (!cs_n1 && mosi1[35]) mem[mosi1[9:0]] <= mosi1[34:19];
        low3 <= cs_n3 ? 0 : low3 + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        req = 1'b1; we = v.w; addr = v.a; wdata = v.d;
        @(negedge sck);
        chk($sformatf("%s c1", tag), {cs_n1, busy1, ack1, mosi1}, {3'b010, v.lo});
        req = 1'b0; we = ~v.w; addr = 32'h5555_AAA8; wdata = 32'h0F0F_0F0F;
        @(negedge sck);
        chk($sformatf("%s c2", tag), {cs_n1, busy1, ack1, mosi1}, {3'b110, 36'h0});
        @(negedge sck);
        chk($sformatf("%s c3", tag), {cs_n1, busy1, ack1, mosi1}, {3'b010, v.hi});
        @(negedge sck);
        chk($sformatf("%s c4", tag), {cs_n1, busy1, ack1, mosi1}, {3'b111, 36'h0});
        chk($sformatf("%s rdata", tag), rdata1, v.rd);
        @(negedge sck);
        chk($sformatf("%s c5", tag), {cs_n1, busy1, ack1, mosi1}, {3'b100, 36'h0});
    endtask

    initial begin
        logic [15:0] ackm, csm;
        vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, {1'b1, 16'hBEEF, 19'h00008}, {1'b1, 16'hDEAD, 19'h00009}, 32'h0};
        vecs[1] = '{1'b0, 32'h0000_0010, 32'h1111_2222, {1'b0, 16'h0, 19'h00008}, {1'b0, 16'h0, 19'h00009}, 32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 32'hFFF0_0004, 32'h1234_5678, {1'b1, 16'h5678, 19'h00002}, {1'b1, 16'h1234, 19'h00003}, 32'hDEAD_BEEF};
        vecs[3] = '{1'b0, 32'h0000_0004, 32'hFFFF_FFFF, {1'b0, 16'h0, 19'h00002}, {1'b0, 16'h0, 19'h00003}, 32'h1234_5678};
        vecs[4] = '{1'b1, 32'h000F_FFFC, 32'hA5A5_5A5A, {1'b1, 16'h5A5A, 19'h7FFFE}, {1'b1, 16'hA5A5, 19'h7FFFF}, 32'h1234_5678};
        vecs[5] = '{1'b0, 32'hFFFF_FFFF, 32'h0, {1'b0, 16'h0, 19'h7FFFE}, {1'b0, 16'h0, 19'h7FFFF}, 32'hA5A5_5A5A};
        vecs[6] = '{1'b0, 32'h0000_0010, 32'h0, {1'b0, 16'h0, 19'h00008}, {1'b0, 16'h0, 19'h00009}, 32'hDEAD_BEEF};
        vecs[7] = '{1'b0, 32'h0000_0020, 32'h0, {1'b0, 16'h0, 19'h00010}, {1'b0, 16'h0, 19'h00011}, 32'hCAFE_F00D};

        repeat (3) @(negedge sck);
        chk("reset w1", {cs_n1, busy1, ack1, mosi1, rdata1}, {3'b100, 36'h0, 32'h0});
        chk("reset w3", {cs_n3, busy3, ack3, mosi3, rdata3}, {3'b100, 36'h0, 32'h0});
        rst = 1'b0;
        for (int i = 0; i < 7; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // req seen only during DONE must be ignored
        req = 1'b1; we = 1'b0; addr = 32'h10;
        repeat (3) @(negedge sck);
        req = 1'b0;
        @(negedge sck);
        chk("done ack", ack1, 1'b1);
        req = 1'b1;
        @(negedge sck);
        chk("done ignore c5", {busy1, ack1, cs_n1}, 3'b001);
        req = 1'b0;
        @(negedge sck);
        chk("done ignore c6", {busy1, ack1, cs_n1}, 3'b001);

        // back-to-back requests with addr changed mid-access
        ackm = '0;
        req = 1'b1; we = 1'b0; addr = 32'h10;
        for (int c = 1; c <= 14; c++) begin
            @(negedge sck);
            ackm[c] = ack1;
            if (c == 2) addr = 32'h4;
            if (c == 3) chk("b2b c3 mosi", mosi1, {1'b0, 16'h0, 19'h00009});
            if (c == 6) chk("b2b c6 mosi", mosi1, {1'b0, 16'h0, 19'h00002});
            if (c == 14) begin
                chk("b2b rdata", rdata1, 32'h1234_5678);
                req = 1'b0;
            end
        end
        chk("b2b ack cycles", ackm, 16'h4210);
        @(negedge sck);

        // reset in the gap of a write aborts it; req held through reset is taken right after
        req = 1'b1; we = 1'b1; addr = 32'h30; wdata = 32'h1111_2222;
        @(negedge sck);
        @(negedge sck);
        rst = 1'b1; addr = 32'h20; wdata = 32'hCAFE_F00D;
        @(negedge sck);
        chk("rst abort", {cs_n1, busy1, ack1, mosi1, rdata1}, {3'b100, 36'h0, 32'h0});
        rst = 1'b0;
        @(negedge sck);
        chk("rst accept lo", {cs_n1, busy1, ack1, mosi1}, {3'b010, 1'b1, 16'hF00D, 19'h00010});
        req = 1'b0;
        @(negedge sck);
        chk("rst gap", {cs_n1, busy1, ack1, mosi1}, {3'b110, 36'h0});
        @(negedge sck);
        chk("rst hi", {cs_n1, busy1, ack1, mosi1}, {3'b010, 1'b1, 16'hCAFE, 19'h00011});
        @(negedge sck);
        chk("rst ack", {cs_n1, busy1, ack1}, 3'b111);
        @(negedge sck);
        run_txn(vecs[7], "readback");

        // WAIT_CYCLES=3 read
        csm = '0; ackm = '0;
        req3 = 1'b1; we = 1'b0; addr = 32'h10;
        for (int c = 1; c <= 9; c++) begin
            @(negedge sck);
            csm[c] = cs_n3;
            ackm[c] = ack3;
            if (c == 1) begin
                chk("w3 c1 mosi", mosi3, {1'b0, 16'h0, 19'h00008});
                req3 = 1'b0;
            end
            if (c == 8) chk("w3 rdata", rdata3, 32'hDEAD_BEEF);
        end
        chk("w3 cs_n cycles", csm, 16'h0310);
        chk("w3 ack cycles", ackm, 16'h0100);
        chk("w3 idle", busy3, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
